// File: rtl/mcp_sync_pkg.sv
// mcp_sync_pkg: shared constants and helpers for the multi-channel MCP bus
// synchronizer (mcp_bus_sync / mcp_sync_ch).
//   MODE_LEVEL / MODE_TOGGLE : EN_MODE encodings
//   NUM_STAGES_MIN / _MAX    : legal bounds of the enable synchronizer depth
//   qualify()                : turns the synchronized enable into an update strobe
package mcp_sync_pkg;

  localparam int MODE_LEVEL  = 0;  // rising edge of bus_enable qualifies
  localparam int MODE_TOGGLE = 1;  // any edge of bus_enable qualifies

  localparam int NUM_STAGES_MIN = 2;
  localparam int NUM_STAGES_MAX = 4;

  // Edge detector on the synchronized enable. pulse_q is the previous value
  // of sync_last, so the result is high for exactly one cycle per edge.
  function automatic logic qualify(input logic toggle_mode,
                                   input logic sync_last,
                                   input logic pulse_q);
    if (toggle_mode) return sync_last ^ pulse_q;
    else             return sync_last & ~pulse_q;
  endfunction

endpackage

// File: rtl/mcp_sync_ch.sv
// mcp_sync_ch: one channel of the MCP bus synchronizer.
// Only the enable crosses the clock domain through a flop chain; the data
// word is captured directly once the synchronized enable shows an edge,
// relying on the source holding it stable long enough.
// Ports:
//   CLK          destination clock
//   RST          asynchronous active-low reset
//   unsync_data  source data word (quasi-static around the enable edge)
//   bus_enable   source qualifier, asynchronous to CLK
//   sync_data    captured data word (registered)
//   enable_pulse one-cycle strobe marking a sync_data update (registered)
//   update_cnt   wrapping count of updates (registered)
module mcp_sync_ch
  import mcp_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int EN_MODE    = MODE_LEVEL,
  parameter int CNT_W      = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_data,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_data,
  output logic                 enable_pulse,
  output logic [CNT_W-1:0]     update_cnt
);

  localparam logic TOGGLE = (EN_MODE == MODE_TOGGLE);

  logic [NUM_STAGES-1:0] sync;     // sync[0] is the metastability-catching flop
  logic                  pulse_ff; // sync_last delayed one cycle
  logic                  sync_last;
  logic                  qual;

  assign sync_last = sync[NUM_STAGES-1];
  assign qual      = qualify(TOGGLE, sync_last, pulse_ff);

  // Enable synchronizer chain plus the edge-detect history flop. Reset
  // clears the whole chain, which is what aborts an in-flight transfer and
  // makes a high enable at release look like a fresh rising edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync     <= '0;
      pulse_ff <= 1'b0;
    end else begin
      sync     <= {sync[NUM_STAGES-2:0], bus_enable};
      pulse_ff <= sync_last;
    end
  end

  // Capture stage: data word, strobe and counter all move on the same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_data    <= '0;
      enable_pulse <= 1'b0;
      update_cnt   <= '0;
    end else begin
      enable_pulse <= qual;
      if (qual) begin
        sync_data  <= unsync_data;
        update_cnt <= update_cnt + CNT_W'(1);  // wraps silently
      end
    end
  end

endmodule

// File: rtl/mcp_bus_sync.sv
// mcp_bus_sync: multi-channel multi-cycle-path bus synchronizer.
// Each channel carries a BUS_WIDTH data word qualified by its own enable;
// the enable is synchronized into CLK and its edge (rising in level mode,
// either in toggle mode) loads the word, pulses enable_pulse for one cycle
// and bumps a wrapping update counter. Latency from the first CLK edge that
// samples the new enable level to the output update is NUM_STAGES+1 edges.
// Ports:
//   CLK           destination clock (single clock domain)
//   RST           asynchronous active-low reset
//   unsync_bus    NUM_CH*BUS_WIDTH source data, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable    NUM_CH per-channel source qualifiers, asynchronous to CLK
//   sync_bus      NUM_CH*BUS_WIDTH captured data, same packing
//   enable_pulse  NUM_CH one-cycle update strobes
//   update_cnt    NUM_CH*CNT_W per-channel update counters, channel c at [c*CNT_W +: CNT_W]
module mcp_bus_sync
  import mcp_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_CH     = 2,
  parameter int EN_MODE    = MODE_LEVEL,
  parameter int CNT_W      = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH*CNT_W-1:0]     update_cnt
);

  // Parameter legality, caught at elaboration.
  if (NUM_STAGES < NUM_STAGES_MIN || NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_stages
    $error("mcp_bus_sync: NUM_STAGES=%0d outside %0d..%0d",
           NUM_STAGES, NUM_STAGES_MIN, NUM_STAGES_MAX);
  end
  if (EN_MODE != MODE_LEVEL && EN_MODE != MODE_TOGGLE) begin : g_bad_mode
    $error("mcp_bus_sync: EN_MODE=%0d is not a legal mode", EN_MODE);
  end

  // Channel-indexed views of the flat ports.
  logic [NUM_CH-1:0][BUS_WIDTH-1:0] din;
  logic [NUM_CH-1:0][BUS_WIDTH-1:0] dout;
  logic [NUM_CH-1:0][CNT_W-1:0]     cnt;

  assign din        = unsync_bus;
  assign sync_bus   = dout;
  assign update_cnt = cnt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mcp_sync_ch #(
      .NUM_STAGES (NUM_STAGES),
      .BUS_WIDTH  (BUS_WIDTH),
      .EN_MODE    (EN_MODE),
      .CNT_W      (CNT_W)
    ) u_ch (
      .CLK          (CLK),
      .RST          (RST),
      .unsync_data  (din[c]),
      .bus_enable   (bus_enable[c]),
      .sync_data    (dout[c]),
      .enable_pulse (enable_pulse[c]),
      .update_cnt   (cnt[c])
    );
  end

endmodule

// File: tb/tb_mcp_bus_sync.sv
// Bench for mcp_bus_sync: a level-mode instance with default parameters and
// a toggle-mode instance (NUM_STAGES=3, CNT_W=2). Each enable edge driven
// pushes the expected data, count and arrival edge onto a per-channel
// queue; a negedge monitor pops and compares on every enable_pulse.
module tb_mcp_bus_sync;

  localparam int NS_L = 2;
  localparam int NS_T = 3;

  typedef struct {
    logic [7:0] d;
    int         cnt;
    int         cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] ub_l = '0, ub_t = '0;
  logic [1:0]  en_l = '0, en_t = '0;
  logic [15:0] sb_l, sb_t;
  logic [1:0]  ep_l, ep_t;
  logic [15:0] uc_l;
  logic [3:0]  uc_t;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   cnt_l [2] = '{0, 0};
  int   cnt_t [2] = '{0, 0};
  exp_t ql [2][$];
  exp_t qt [2][$];

  mcp_bus_sync #(.NUM_STAGES(NS_L), .BUS_WIDTH(8), .NUM_CH(2), .EN_MODE(0), .CNT_W(8)) dut_l (
    .CLK(CLK), .RST(RST), .unsync_bus(ub_l), .bus_enable(en_l),
    .sync_bus(sb_l), .enable_pulse(ep_l), .update_cnt(uc_l));

  mcp_bus_sync #(.NUM_STAGES(NS_T), .BUS_WIDTH(8), .NUM_CH(2), .EN_MODE(1), .CNT_W(2)) dut_t (
    .CLK(CLK), .RST(RST), .unsync_bus(ub_t), .bus_enable(en_t),
    .sync_bus(sb_t), .enable_pulse(ep_t), .update_cnt(uc_t));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Level instance: only a 0->1 enable change yields an update.
  task automatic drv_l(input int c, input logic v, input logic [7:0] d);
    exp_t e;
    ub_l[c*8 +: 8] = d;
    if (v && !en_l[c]) begin
      cnt_l[c] = (cnt_l[c] + 1) % 256;
      e.d = d; e.cnt = cnt_l[c]; e.cyc = cyc + NS_L + 1;
      ql[c].push_back(e);
    end
    en_l[c] = v;
  endtask

  // Toggle instance: any enable change yields an update.
  task automatic drv_t(input int c, input logic v, input logic [7:0] d);
    exp_t e;
    ub_t[c*8 +: 8] = d;
    if (v != en_t[c]) begin
      cnt_t[c] = (cnt_t[c] + 1) % 4;
      e.d = d; e.cnt = cnt_t[c]; e.cyc = cyc + NS_T + 1;
      qt[c].push_back(e);
    end
    en_t[c] = v;
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (RST) begin
      for (int c = 0; c < 2; c++) begin
        if (ep_l[c]) begin
          if (ql[c].size() == 0) chk($sformatf("l%0d_spurious_pulse", c), ql[c].size(), 1);
          else begin
            e = ql[c].pop_front();
            chk($sformatf("l%0d_data", c), sb_l[c*8 +: 8], e.d);
            chk($sformatf("l%0d_cnt", c),  uc_l[c*8 +: 8], e.cnt);
            chk($sformatf("l%0d_edge", c), cyc, e.cyc);
          end
        end
        if (ep_t[c]) begin
          if (qt[c].size() == 0) chk($sformatf("t%0d_spurious_pulse", c), qt[c].size(), 1);
          else begin
            e = qt[c].pop_front();
            chk($sformatf("t%0d_data", c), sb_t[c*8 +: 8], e.d);
            chk($sformatf("t%0d_cnt", c),  uc_t[c*2 +: 2], e.cnt);
            chk($sformatf("t%0d_edge", c), cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(3);
    chk("rst_sb_l", sb_l, 0); chk("rst_ep_l", ep_l, 0); chk("rst_uc_l", uc_l, 0);
    chk("rst_sb_t", sb_t, 0); chk("rst_ep_t", ep_t, 0); chk("rst_uc_t", uc_t, 0);
    RST = 1'b1;
    tick(3);

    // Level mode, single channel update; ch1 must stay untouched
    drv_l(0, 1'b1, 8'hA5);
    tick(6);
    chk("l_a5_data", sb_l[7:0], 8'hA5);
    chk("l_a5_cnt", uc_l[7:0], 1);
    chk("l_ch1_hold", sb_l[15:8], 8'h00);
    chk("l_ch1_cnt", uc_l[15:8], 0);

    // Held high ~20 cycles, then low: still a single pulse
    tick(14);
    drv_l(0, 1'b0, 8'hFF);
    tick(10);
    chk("l_hold_cnt", uc_l[7:0], 1);
    chk("l_hold_data", sb_l[7:0], 8'hA5);

    // Both channels on the same edge
    drv_l(0, 1'b1, 8'h11);
    drv_l(1, 1'b1, 8'h22);
    tick(8);
    chk("l_both_bus", sb_l, 16'h2211);
    chk("l_both_cnt", uc_l, {8'd1, 8'd2});

    // Toggle mode: one update per transition
    drv_t(1, 1'b1, 8'h3C);
    tick(10);
    chk("t_rise_data", sb_t[15:8], 8'h3C);
    drv_t(1, 1'b0, 8'hC3);
    tick(10);
    chk("t_fall_data", sb_t[15:8], 8'hC3);
    chk("t_ch1_cnt", uc_t[3:2], 2);

    // Counter wrap on a 2-bit counter: 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      drv_t(0, ~en_t[0], 8'(8'h40 + i));
      tick(10);
      chk($sformatf("t_wrap%0d", i), uc_t[1:0], cnt_t[0]);
    end

    // Reset one cycle after an enable rise aborts the transfer
    drv_l(0, 1'b0, 8'h00);
    drv_l(1, 1'b0, 8'h00);
    tick(8);
    drv_l(0, 1'b1, 8'h5A);
    tick(1);
    RST = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      ql[c].delete(); qt[c].delete();
      cnt_l[c] = 0; cnt_t[c] = 0;
    end
    chk("mid_rst_sb_l", sb_l, 0); chk("mid_rst_ep_l", ep_l, 0); chk("mid_rst_uc_l", uc_l, 0);
    chk("mid_rst_sb_t", sb_t, 0); chk("mid_rst_uc_t", uc_t, 0);
    tick(3);
    chk("in_rst_ep_l", ep_l, 0);
    // Release with enables still high: each high enable counts as a fresh edge
    RST = 1'b1;
    for (int c = 0; c < 2; c++) begin
      if (en_l[c]) begin
        en_l[c] = 1'b0;
        drv_l(c, 1'b1, ub_l[c*8 +: 8]);
      end
      if (en_t[c]) begin
        en_t[c] = 1'b0;
        drv_t(c, 1'b1, ub_t[c*8 +: 8]);
      end
    end
    tick(10);
    chk("rel_data_l", sb_l[7:0], 8'h5A);
    chk("rel_cnt_l", uc_l[7:0], 1);

    for (int c = 0; c < 2; c++) begin
      chk($sformatf("l%0d_missing", c), ql[c].size(), 0);
      chk($sformatf("t%0d_missing", c), qt[c].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
